// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Owns the PC, fetches one instruction
//               from memory via a req/ready + rvalid handshake, and presents it
//               to decode. Halts permanently on Finish_Prog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    input  logic        Finish_Prog,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] Instr,
    output logic        Instr_valid,
    output logic        Halted
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;
    // Jump targets are forced word-aligned; low bits of PCTarget are discarded.
    assign w_target   = PCTarget & ~32'h0000_0003;
    assign w_next_pc  = PCSrc ? w_target : w_pc_plus4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        r_instr       <= imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Finish_Prog outranks PCSrc; PC is frozen at the final instruction.
                    if (!stall) begin
                        r_instr_valid <= 1'b0;
                        if (Finish_Prog) begin
                            r_instr <= NOP_INSTR;
                            r_state <= S_HALT;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = r_pc;
    assign PC          = r_pc;
    assign PCPlus4     = w_pc_plus4;
    assign Instr       = r_instr;
    assign Instr_valid = r_instr_valid;
    assign Halted      = (r_state == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Table-driven self-checking bench for fetch_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        Finish_Prog;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic        Halted;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .Finish_Prog (Finish_Prog),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .Instr       (Instr),
        .Instr_valid (Instr_valid),
        .Halted      (Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        pcsrc;
        logic [31:0] target;
        logic        finish;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic        e_ichk;
        logic        e_halt;
    } vec_t;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t tbl [23];

    function automatic vec_t v(input logic rdy, input logic rv, input logic [31:0] rd,
                               input logic st, input logic ps, input logic [31:0] tg,
                               input logic fin, input logic ereq, input logic [31:0] epc,
                               input logic evld, input logic [31:0] ein, input logic eic,
                               input logic ehlt);
        vec_t r;
        r.ready = rdy; r.rvalid = rv; r.rdata = rd; r.stall = st; r.pcsrc = ps;
        r.target = tg; r.finish = fin; r.e_req = ereq; r.e_pc = epc;
        r.e_valid = evld; r.e_instr = ein; r.e_ichk = eic; r.e_halt = ehlt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Called just after a falling edge: drive, check state-derived outputs, advance.
    task automatic apply(input string tag, input vec_t x);
        imem_ready  = x.ready;
        imem_rvalid = x.rvalid;
        imem_rdata  = x.rdata;
        stall       = x.stall;
        PCSrc       = x.pcsrc;
        PCTarget    = x.target;
        Finish_Prog = x.finish;
        #1;
        chk({tag, ".req"},   {31'd0, imem_req},    {31'd0, x.e_req});
        chk({tag, ".addr"},  imem_addr,            x.e_pc);
        chk({tag, ".pc"},    PC,                   x.e_pc);
        chk({tag, ".pc4"},   PCPlus4,              x.e_pc + 32'd4);
        chk({tag, ".valid"}, {31'd0, Instr_valid}, {31'd0, x.e_valid});
        chk({tag, ".halt"},  {31'd0, Halted},      {31'd0, x.e_halt});
        if (x.e_ichk)
            chk({tag, ".instr"}, Instr, x.e_instr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
        stall = 0; PCSrc = 0; PCTarget = 0; Finish_Prog = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        // ready rv rdata st ps target fin | req pc valid instr ichk halt
        tbl[0]  = v(0,0,0,            0,0,0,      0, 0,32'h0,  0,NOP,          1,0);
        tbl[1]  = v(1,0,0,            0,0,0,      0, 1,32'h0,  0,NOP,          1,0);
        tbl[2]  = v(0,1,32'h00500093, 0,0,0,      0, 0,32'h0,  0,NOP,          1,0);
        tbl[3]  = v(0,0,0,            0,1,32'h12, 0, 0,32'h0,  1,32'h00500093, 1,0);
        tbl[4]  = v(1,0,0,            0,0,0,      0, 1,32'h10, 0,0,            0,0);
        tbl[5]  = v(0,1,32'h00A00113, 0,0,0,      0, 0,32'h10, 0,0,            0,0);
        tbl[6]  = v(0,0,0,            0,0,32'h3FC,0, 0,32'h10, 1,32'h00A00113, 1,0);
        tbl[7]  = v(0,0,0,            0,0,0,      0, 1,32'h14, 0,0,            0,0);
        tbl[8]  = v(1,0,0,            0,0,0,      0, 1,32'h14, 0,0,            0,0);
        tbl[9]  = v(0,0,0,            0,0,0,      0, 0,32'h14, 0,0,            0,0);
        tbl[10] = v(0,1,32'h002081B3, 0,0,0,      0, 0,32'h14, 0,0,            0,0);
        tbl[11] = v(0,0,0,            0,1,32'h103,0, 0,32'h14, 1,32'h002081B3, 1,0);
        tbl[12] = v(1,0,0,            0,0,0,      0, 1,32'h100,0,0,            0,0);
        tbl[13] = v(0,1,32'h00000513, 0,0,0,      0, 0,32'h100,0,0,            0,0);
        tbl[14] = v(1,1,0,            1,1,32'h200,0, 0,32'h100,1,32'h00000513, 1,0);
        tbl[15] = v(1,1,0,            1,0,32'h200,0, 0,32'h100,1,32'h00000513, 1,0);
        tbl[16] = v(1,1,0,            1,1,32'h300,0, 0,32'h100,1,32'h00000513, 1,0);
        tbl[17] = v(1,1,0,            1,0,32'h300,0, 0,32'h100,1,32'h00000513, 1,0);
        tbl[18] = v(0,0,0,            0,1,32'h203,0, 0,32'h100,1,32'h00000513, 1,0);
        tbl[19] = v(1,0,0,            0,0,0,      0, 1,32'h200,0,0,            0,0);
        tbl[20] = v(0,1,32'h00100073, 0,0,0,      0, 0,32'h200,0,0,            0,0);
        tbl[21] = v(0,0,0,            0,1,32'h400,1, 0,32'h200,1,32'h00100073, 1,0);
        tbl[22] = v(1,1,32'hDEAD0000, 0,0,0,      0, 0,32'h200,0,NOP,          1,1);

        do_reset();
        for (int i = 0; i < 23; i++)
            apply($sformatf("tbl%0d", i), tbl[i]);

        // Halt is sticky: memory offering everything still produces no fetch.
        for (int i = 0; i < 20; i++)
            apply($sformatf("halt%0d", i), v(1,1,32'hBAD0BAD0,0,1,32'h800,0, 0,32'h200,0,NOP,1,1));

        // Reset during WAIT; stale rvalid in IDLE/REQ must be dropped.
        do_reset();
        apply("r5_idle", v(0,0,0,0,0,0,0, 0,32'h0,0,NOP,1,0));
        apply("r5_req",  v(1,0,0,0,0,0,0, 1,32'h0,0,NOP,1,0));
        apply("r5_wait", v(0,0,0,0,0,0,0, 0,32'h0,0,NOP,1,0));
        rst = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBADBAD00;
        #1;
        chk("r5_async.valid", {31'd0, Instr_valid}, 32'd0);
        chk("r5_async.req",   {31'd0, imem_req},    32'd0);
        chk("r5_async.instr", Instr,                NOP);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        apply("r5_idle2", v(0,1,32'hBADBAD01,0,0,0,0, 0,32'h0,0,NOP,1,0));
        apply("r5_req2",  v(0,1,32'hBADBAD02,0,0,0,0, 1,32'h0,0,NOP,1,0));
        apply("r5_req3",  v(1,1,32'hBADBAD03,0,0,0,0, 1,32'h0,0,NOP,1,0));
        apply("r5_wait2", v(0,1,32'h00300193,0,0,0,0, 0,32'h0,0,NOP,1,0));
        apply("r5_issue", v(0,0,0,1,0,0,0,            0,32'h0,1,32'h00300193,1,0));

        // PC wrap at the top of the address space, with a slow ready.
        do_reset();
        apply("w_idle",  v(0,0,0,0,0,0,0,                    0,32'h0,0,NOP,1,0));
        apply("w_req",   v(1,0,0,0,0,0,0,                    1,32'h0,0,NOP,1,0));
        apply("w_wait",  v(0,1,32'h0040006F,0,0,0,0,         0,32'h0,0,NOP,1,0));
        apply("w_iss",   v(0,0,0,0,1,32'hFFFF_FFFF,0,        0,32'h0,1,32'h0040006F,1,0));
        apply("w_req2",  v(1,0,0,0,0,0,0,                    1,32'hFFFF_FFFC,0,0,0,0));
        apply("w_wait2", v(0,1,32'h00000093,0,0,0,0,         0,32'hFFFF_FFFC,0,0,0,0));
        apply("w_iss2",  v(0,0,0,0,0,0,0,                    0,32'hFFFF_FFFC,1,32'h00000093,1,0));
        for (int i = 0; i < 5; i++)
            apply($sformatf("w_hold%0d", i), v(0,0,0,0,0,0,0, 1,32'h0,0,0,0,0));
        apply("w_req3",  v(1,0,0,0,0,0,0,                    1,32'h0,0,0,0,0));
        apply("w_wait3", v(0,1,32'h00000113,0,0,0,0,         0,32'h0,0,0,0,0));
        apply("w_iss3",  v(0,0,0,1,0,0,0,                    0,32'h0,1,32'h00000113,1,0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
